// File: rtl/cache_line_refill_pkg.sv
// Shared cache package: refill FSM state encoding, line geometry and the
// AXI4 read-channel constants used by the line refill engine.
package cache_line_refill_pkg;

    // Refill engine states: wait for a miss, issue the burst address,
    // collect the beats, then write the packed line into the BRAM.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        DATA  = 2'd2,
        WRITE = 2'd3
    } RefillState;

    localparam int LINE_WORDS = 8;
    localparam int LINE_BITS  = 256;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP = 2'b10;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/cache_line_refill.sv
// Data cache line refill engine. On a miss it issues one 8-beat AXI4 read
// burst, packs the beats into a 256-bit line and hands the line to the BRAM
// with a single-cycle write strobe.
//
// Build option: define REFILL_CRITICAL_WORD_EN to fetch critical-word-first
// with a WRAP burst starting at the missing word; otherwise the line is read
// with an INCR burst from the line-aligned address.
module cache_line_refill
    import cache_line_refill_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int LINE_WORDS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [31:0]           req_paddr,
    input  logic [ADDR_WIDTH-1:0] req_waddr,
    output logic [31:0]           araddr,
    output logic [7:0]            arlen,
    output logic [2:0]            arsize,
    output logic [1:0]            arburst,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [31:0]           rdata,
    input  logic [1:0]            rresp,
    input  logic                  rlast,
    input  logic                  rvalid,
    output logic                  rready,
    output logic                  line_we,
    output logic [ADDR_WIDTH-1:0] line_waddr,
    output logic [LINE_BITS-1:0]  line_data,
    output logic                  done,
    output logic                  err,
    output logic                  crit_valid,
    output logic [31:0]           crit_data
);

    localparam logic [2:0] LAST_BEAT = 3'(LINE_WORDS - 1);

    RefillState                state_q;
    logic [2:0]                beatCnt_q;
    logic [2:0]                offset_q;
    logic [2:0]                start_q;
    logic [ADDR_WIDTH-4:0]     setBase_q;
    logic                      errAcc_q;

    logic                      reqReady_q;
    logic [31:0]               araddr_q;
    logic                      arvalid_q;
    logic                      rready_q;
    logic                      lineWe_q;
    logic [ADDR_WIDTH-1:0]     lineWaddr_q;
    logic [LINE_BITS-1:0]      lineData_q;
    logic                      done_q;
    logic                      err_q;
    logic                      critValid_q;
    logic [31:0]               critData_q;

    logic [2:0]                beatWord;
    logic                      lastBeat;
    logic                      beatErr;
    logic                      unusedBits;

    // Word slot for the current beat, whether it closes the burst, and
    // whether it breaks the response/rlast rules.
    assign beatWord   = start_q + beatCnt_q;
    assign lastBeat   = (beatCnt_q == LAST_BEAT);
    assign beatErr    = (rresp != AXI_RESP_OKAY) || (rlast != lastBeat);
    assign unusedBits = ^{req_paddr[1:0], req_waddr[2:0]};

    // Refill FSM with all interface outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            beatCnt_q   <= 3'd0;
            offset_q    <= 3'd0;
            start_q     <= 3'd0;
            setBase_q   <= '0;
            errAcc_q    <= 1'b0;
            reqReady_q  <= 1'b1;
            araddr_q    <= 32'd0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            lineWe_q    <= 1'b0;
            lineWaddr_q <= '0;
            lineData_q  <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            critValid_q <= 1'b0;
            critData_q  <= 32'd0;
        end else begin
            lineWe_q    <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            critValid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid && reqReady_q) begin
                        reqReady_q <= 1'b0;
                        arvalid_q  <= 1'b1;
                        offset_q   <= req_paddr[4:2];
                        setBase_q  <= req_waddr[ADDR_WIDTH-1:3];
                        beatCnt_q  <= 3'd0;
                        errAcc_q   <= 1'b0;
`ifdef REFILL_CRITICAL_WORD_EN
                        araddr_q   <= {req_paddr[31:2], 2'b00};
                        start_q    <= req_paddr[4:2];
`else
                        araddr_q   <= {req_paddr[31:5], 5'b00000};
                        start_q    <= 3'd0;
`endif
                        state_q    <= ADDR;
                    end
                end
                ADDR: begin
                    if (arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= DATA;
                    end
                end
                DATA: begin
                    if (rvalid) begin
                        lineData_q[{beatWord, 5'b00000} +: 32] <= rdata;
                        beatCnt_q <= beatCnt_q + 3'd1;
                        errAcc_q  <= errAcc_q | beatErr;
                        if (beatWord == offset_q) begin
                            critValid_q <= 1'b1;
                            critData_q  <= rdata;
                        end
                        if (lastBeat) begin
                            rready_q    <= 1'b0;
                            lineWe_q    <= 1'b1;
                            done_q      <= 1'b1;
                            err_q       <= errAcc_q | beatErr;
                            lineWaddr_q <= {setBase_q, 3'b000};
                            state_q     <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    reqReady_q <= 1'b1;
                    state_q    <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready  = reqReady_q;
    assign araddr     = araddr_q;
    assign arlen      = 8'(LINE_WORDS - 1);
    assign arsize     = AXI_SIZE_4B;
`ifdef REFILL_CRITICAL_WORD_EN
    assign arburst    = AXI_BURST_WRAP;
`else
    assign arburst    = AXI_BURST_INCR;
`endif
    assign arvalid    = arvalid_q;
    assign rready     = rready_q;
    assign line_we    = lineWe_q;
    assign line_waddr = lineWaddr_q;
    assign line_data  = lineData_q;
    assign done       = done_q;
    assign err        = err_q;
    assign crit_valid = critValid_q;
    assign crit_data  = critData_q;

endmodule

// File: tb/tb_cache_line_refill.sv
// Self-checking bench for cache_line_refill: directed and randomized refills
// compared against a line-level reference model of the burst.
module tb_cache_line_refill;

    localparam int ADDR_WIDTH = 10;

    logic                  clk;
    logic                  rst;
    logic                  req_valid;
    logic                  req_ready;
    logic [31:0]           req_paddr;
    logic [ADDR_WIDTH-1:0] req_waddr;
    logic [31:0]           araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arvalid;
    logic                  arready;
    logic [31:0]           rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;
    logic                  line_we;
    logic [ADDR_WIDTH-1:0] line_waddr;
    logic [255:0]          line_data;
    logic                  done;
    logic                  err;
    logic                  crit_valid;
    logic [31:0]           crit_data;

    int checksTotal  = 0;
    int checksPassed = 0;
    int cycleCnt     = 0;

    cache_line_refill #(.ADDR_WIDTH(ADDR_WIDTH), .LINE_WORDS(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_paddr(req_paddr), .req_waddr(req_waddr),
        .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .line_we(line_we), .line_waddr(line_waddr), .line_data(line_data),
        .done(done), .err(err), .crit_valid(crit_valid), .crit_data(crit_data)
    );

    // Free-running clock and an edge counter used for latency checks.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checksTotal++;
        if (got === exp) checksPassed++;
        else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // One full refill: drives the request and a behavioural AXI slave, and
    // predicts the line purely from address arithmetic and the beat list.
    task automatic applyStimulus(input logic [31:0] paddr, input logic [ADDR_WIDTH-1:0] waddr,
                                 input int arDelay, input int gapMode, input int beatNumData,
                                 input int errBeat, input int earlyBeat, input int rstBeat,
                                 input int checkLatency);
        logic [31:0]  expAraddr;
        logic [1:0]   expBurst;
        int           off;
        int           start;
        logic [31:0]  expLine [8];
        logic [255:0] expPacked;
        logic         expErr;
        logic         critPrev;
        logic [31:0]  critDataPrev;
        int           b;
        int           budget;
        int           cyc0;
        int           idx;

        off = int'(paddr[4:2]);
`ifdef REFILL_CRITICAL_WORD_EN
        expAraddr = {paddr[31:2], 2'b00};
        expBurst  = 2'b10;
        start     = off;
`else
        expAraddr = {paddr[31:5], 5'b00000};
        expBurst  = 2'b01;
        start     = 0;
`endif
        for (int k = 0; k < 8; k++) expLine[k] = 32'd0;
        expErr = 1'b0;

        checkOutput("req_ready_idle", req_ready, 1'b1);
        req_valid = 1'b1;
        req_paddr = paddr;
        req_waddr = waddr;
        cyc0 = cycleCnt;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("arvalid", arvalid, 1'b1);
        checkOutput("araddr", araddr, expAraddr);
        checkOutput("arburst", arburst, expBurst);
        checkOutput("arlen", arlen, 8'd7);
        checkOutput("arsize", arsize, 3'b010);
        checkOutput("req_ready_busy", req_ready, 1'b0);

        for (int i = 0; i < arDelay; i++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("arvalid_hold", arvalid, 1'b1);
            checkOutput("araddr_stable", araddr, expAraddr);
        end
        arready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        arready = 1'b0;
        checkOutput("arvalid_drop", arvalid, 1'b0);

        critPrev = 1'b0;
        critDataPrev = 32'd0;
        b = 0;
        budget = 0;
        while (b < 8 && budget < 300) begin
            checkOutput("crit_valid", crit_valid, critPrev);
            if (critPrev) checkOutput("crit_data", crit_data, critDataPrev);
            if (b == 0) checkOutput("rready", rready, 1'b1);
            if (rstBeat >= 0 && b == rstBeat) begin
                rst = 1'b1;
                @(posedge clk);
                @(negedge clk);
                rst = 1'b0;
                checkOutput("rst_req_ready", req_ready, 1'b1);
                checkOutput("rst_rready", rready, 1'b0);
                checkOutput("rst_arvalid", arvalid, 1'b0);
                checkOutput("rst_line_we", line_we, 1'b0);
                checkOutput("rst_line_data", line_data, 256'd0);
                for (int i = 0; i < 3; i++) begin
                    @(posedge clk);
                    @(negedge clk);
                    checkOutput("rst_no_line_we", line_we, 1'b0);
                end
                return;
            end
            rvalid = (gapMode != 0) ? (budget % 2 == 1) : 1'b1;
            if (rvalid) begin
                rdata = (beatNumData != 0) ? 32'(b) : $urandom;
                rresp = (b == errBeat) ? 2'b10 : 2'b00;
                rlast = (b == 7) || (b == earlyBeat);
            end
            @(posedge clk);
            if (rvalid) begin
                idx = (start + b) % 8;
                expLine[idx] = rdata;
                if (rresp != 2'b00 || rlast != (b == 7)) expErr = 1'b1;
                critPrev = (idx == off);
                critDataPrev = rdata;
                b++;
            end else begin
                critPrev = 1'b0;
            end
            @(negedge clk);
            rvalid = 1'b0;
            rlast  = 1'b0;
            rresp  = 2'b00;
            budget++;
        end
        if (b < 8) begin
            checkOutput("beat_timeout", 1'b0, 1'b1);
            return;
        end

        expPacked = '0;
        for (int k = 0; k < 8; k++) expPacked[32*k +: 32] = expLine[k];
        checkOutput("crit_valid_last", crit_valid, critPrev);
        if (critPrev) checkOutput("crit_data_last", crit_data, critDataPrev);
        checkOutput("line_we", line_we, 1'b1);
        checkOutput("done", done, 1'b1);
        checkOutput("err", err, expErr);
        checkOutput("line_waddr", line_waddr, {waddr[ADDR_WIDTH-1:3], 3'b000});
        checkOutput("line_data", line_data, expPacked);
        if (checkLatency != 0) checkOutput("done_latency", 32'(cycleCnt - cyc0), 32'd10);

        @(posedge clk);
        @(negedge clk);
        checkOutput("line_we_pulse", line_we, 1'b0);
        checkOutput("done_pulse", done, 1'b0);
        checkOutput("req_ready_back", req_ready, 1'b1);
        checkOutput("line_data_hold", line_data, expPacked);
        checkOutput("line_waddr_hold", line_waddr, {waddr[ADDR_WIDTH-1:3], 3'b000});
    endtask

    // Reset, directed scenarios from the test plan, then random refills.
    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_paddr = 32'd0; req_waddr = '0;
        arready = 1'b0; rdata = 32'd0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_req_ready", req_ready, 1'b1);
        checkOutput("rst_arvalid", arvalid, 1'b0);
        checkOutput("rst_rready", rready, 1'b0);
        checkOutput("rst_line_we", line_we, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_err", err, 1'b0);
        checkOutput("rst_crit_valid", crit_valid, 1'b0);
        checkOutput("rst_line_data", line_data, 256'd0);
        checkOutput("rst_line_waddr", line_waddr, 10'd0);
        checkOutput("rst_araddr", araddr, 32'd0);
        checkOutput("rst_crit_data", crit_data, 32'd0);

        applyStimulus(32'h1000_0044, 10'h2A1, 0, 0, 1, -1, -1, -1, 1);
        applyStimulus(32'h1000_0044, 10'h2A1, 3, 1, 0, -1, -1, -1, 0);
        applyStimulus(32'h2345_6788, 10'h155, 0, 0, 0, 4, -1, -1, 1);
        applyStimulus(32'h2345_6790, 10'h0F7, 0, 0, 0, -1, -1, -1, 1);
        applyStimulus(32'h0ABC_DE5C, 10'h3FF, 1, 0, 0, -1, 5, -1, 0);
        applyStimulus(32'h0000_1018, 10'h012, 0, 0, 0, -1, -1, 4, 0);
        applyStimulus(32'h0000_1018, 10'h012, 0, 0, 1, -1, -1, -1, 1);

        for (int t = 0; t < 12; t++) begin
            applyStimulus($urandom, 10'($urandom_range(0, 1023)), $urandom_range(0, 3),
                          $urandom_range(0, 1), 0,
                          ($urandom_range(0, 2) == 0) ? $urandom_range(0, 7) : -1,
                          ($urandom_range(0, 3) == 0) ? $urandom_range(0, 6) : -1,
                          -1, 0);
        end

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
